// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of signals between the writeback arbiter and its neighbours:
// ALU result handshake, load issue/return, regfile write port and decode read operands.
interface rf_wb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) ();
   logic            i_alu_valid;
   logic [AW-1:0]   i_alu_rd;
   logic [XLEN-1:0] i_alu_data;
   logic            o_alu_ready;

   logic            i_ld_issue;
   logic [AW-1:0]   i_ld_issue_rd;
   logic            o_ld_issue_ready;

   logic            i_ld_valid;
   logic [AW-1:0]   i_ld_rd;
   logic [XLEN-1:0] i_ld_data;
   logic            o_ld_err;

   logic            o_w_ena;
   logic [AW-1:0]   o_w_addr;
   logic [XLEN-1:0] o_w_data;

   logic [AW-1:0]   i_a_addr;
   logic [AW-1:0]   i_b_addr;
   logic [XLEN-1:0] i_rf_a_data;
   logic [XLEN-1:0] i_rf_b_data;
   logic [XLEN-1:0] o_a_data;
   logic [XLEN-1:0] o_b_data;
   logic            o_a_hazard;
   logic            o_b_hazard;
   logic [AW:0]     o_pending_cnt;

   // Pipeline side: drives requests, operand addresses and regfile read data.
   modport master (
      output i_alu_valid, i_alu_rd, i_alu_data,
      output i_ld_issue, i_ld_issue_rd,
      output i_ld_valid, i_ld_rd, i_ld_data,
      output i_a_addr, i_b_addr, i_rf_a_data, i_rf_b_data,
      input  o_alu_ready, o_ld_issue_ready, o_ld_err,
      input  o_w_ena, o_w_addr, o_w_data,
      input  o_a_data, o_b_data, o_a_hazard, o_b_hazard, o_pending_cnt
   );

   // Arbiter side.
   modport slave (
      input  i_alu_valid, i_alu_rd, i_alu_data,
      input  i_ld_issue, i_ld_issue_rd,
      input  i_ld_valid, i_ld_rd, i_ld_data,
      input  i_a_addr, i_b_addr, i_rf_a_data, i_rf_b_data,
      output o_alu_ready, o_ld_issue_ready, o_ld_err,
      output o_w_ena, o_w_addr, o_w_data,
      output o_a_data, o_b_data, o_a_hazard, o_b_hazard, o_pending_cnt
   );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: merges ALU results and out-of-order load returns onto the
// single regfile write port, tracks outstanding loads per register and forwards
// the in-flight write to both decode operands.
module rf_writeback_arbiter #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic    i_clk,
   input  logic    i_reset,
   rf_wb_if.slave  bus
);

   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic [NREGS-1:0] scoreboard;
   logic            ld_err;

   logic ld_accept;
   logic ld_bad;
   logic alu_ready;
   logic alu_fire;
   logic issue_ready;
   logic issue_set;
   logic [AW:0] pending_cnt;

   // Request decode against the registered scoreboard.
   // An issue to the rd whose load is returning this same cycle is allowed:
   // the return frees the entry and the new load immediately re-claims it.
   always_comb begin
      ld_accept   = bus.i_ld_valid && (bus.i_ld_rd != '0) && scoreboard[bus.i_ld_rd];
      ld_bad      = bus.i_ld_valid && (bus.i_ld_rd != '0) && !scoreboard[bus.i_ld_rd];
      alu_ready   = !bus.i_ld_valid && !((bus.i_alu_rd != '0) && scoreboard[bus.i_alu_rd]);
      alu_fire    = bus.i_alu_valid && alu_ready;
      issue_ready = (bus.i_ld_issue_rd == '0) || !scoreboard[bus.i_ld_issue_rd] ||
                    (ld_accept && (bus.i_ld_rd == bus.i_ld_issue_rd));
      issue_set   = bus.i_ld_issue && (bus.i_ld_issue_rd != '0) && issue_ready;
   end

   // Write-stage register; loads win over ALU results, address/data hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         ld_err   <= 1'b0;
      end else begin
         ld_err <= ld_bad;
         if (ld_accept) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.i_ld_rd;
            wb_data  <= bus.i_ld_data;
         end else if (alu_fire) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.i_alu_rd;
            wb_data  <= bus.i_alu_data;
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

   // Load-pending scoreboard; a new issue overrides a same-cycle clear.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         scoreboard <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (issue_set && (bus.i_ld_issue_rd == AW'(i)))
               scoreboard[i] <= 1'b1;
            else if (ld_accept && (bus.i_ld_rd == AW'(i)))
               scoreboard[i] <= 1'b0;
         end
      end
   end

   // Population count of outstanding loads.
   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < NREGS; i++)
         pending_cnt = pending_cnt + (AW+1)'(scoreboard[i]);
   end

   // Outputs: regfile write port, handshakes, forwarding and hazards.
   always_comb begin
      bus.o_alu_ready      = alu_ready;
      bus.o_ld_issue_ready = issue_ready;
      bus.o_ld_err         = ld_err;
      bus.o_w_ena          = wb_valid && (wb_addr != '0);
      bus.o_w_addr         = wb_addr;
      bus.o_w_data         = wb_data;
      bus.o_pending_cnt    = pending_cnt;

      if (bus.i_a_addr == '0)
         bus.o_a_data = '0;
      else if (wb_valid && (wb_addr == bus.i_a_addr))
         bus.o_a_data = wb_data;
      else
         bus.o_a_data = bus.i_rf_a_data;

      if (bus.i_b_addr == '0)
         bus.o_b_data = '0;
      else if (wb_valid && (wb_addr == bus.i_b_addr))
         bus.o_b_data = wb_data;
      else
         bus.o_b_data = bus.i_rf_b_data;

      bus.o_a_hazard = (bus.i_a_addr != '0) && scoreboard[bus.i_a_addr];
      bus.o_b_hazard = (bus.i_b_addr != '0) && scoreboard[bus.i_b_addr];
   end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed vector table, hand sequences for
// reset and same-rd corner cases, then randomized traffic against a reference model.
module tb_rf_writeback_arbiter;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   always #5 i_clk = ~i_clk;

   rf_wb_if #(.XLEN(XLEN), .AW(AW)) bus ();

   rf_writeback_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic iss, input logic [4:0] ird,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] aa, input logic [4:0] ba,
                        input logic [31:0] rfa, input logic [31:0] rfb);
      bus.i_alu_valid   = av;  bus.i_alu_rd = ard; bus.i_alu_data = ad;
      bus.i_ld_issue    = iss; bus.i_ld_issue_rd = ird;
      bus.i_ld_valid    = lv;  bus.i_ld_rd = lrd;  bus.i_ld_data = ld;
      bus.i_a_addr      = aa;  bus.i_b_addr = ba;
      bus.i_rf_a_data   = rfa; bus.i_rf_b_data = rfb;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] ad;
      logic iss; logic [4:0] ird;
      logic lv; logic [4:0] lrd; logic [31:0] ld;
      logic [4:0] aa; logic [4:0] ba; logic [31:0] rfa;
      logic e_rdy; logic e_wen; logic [4:0] e_wa; logic [31:0] e_wd;
      logic [31:0] e_ad; logic e_bh; int e_cnt; logic e_err;
   } vec_t;

   vec_t vt[20];

   // Reference model state: set of registers with an outstanding load,
   // plus the write currently presented to the regfile.
   bit          m_pend[NREGS];
   bit          m_wv;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   bit          m_err;

   function automatic int m_count();
      int c = 0;
      foreach (m_pend[i]) if (m_pend[i]) c++;
      return c;
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
      if (a == 0) return 0;
      if (m_wv && m_wa == a) return m_wd;
      return rf;
   endfunction

   initial begin
      //        av ard ad        iss ird lv lrd ld         aa ba rfa            rdy wen wa wd        ad        bh cnt err
      vt[0]  = '{0, 0, 0,        0, 0,  0, 0,  0,         3, 0, 32'h55,        1,  0,  0, 0,        32'h55,   0, 0, 0};
      vt[1]  = '{0, 0, 0,        0, 0,  0, 0,  0,         0, 0, 32'hFFFFFFFF,  1,  0,  0, 0,        0,        0, 0, 0};
      vt[2]  = '{1, 5, 32'h1234, 0, 0,  0, 0,  0,         0, 0, 0,             1,  0,  0, 0,        0,        0, 0, 0};
      vt[3]  = '{0, 0, 0,        0, 0,  0, 0,  0,         5, 0, 0,             1,  1,  5, 32'h1234, 32'h1234, 0, 0, 0};
      vt[4]  = '{0, 0, 0,        1, 7,  0, 0,  0,         0, 7, 0,             1,  0,  0, 0,        0,        0, 0, 0};
      vt[5]  = '{1, 7, 32'hBEEF, 0, 0,  0, 0,  0,         0, 7, 0,             0,  0,  0, 0,        0,        1, 1, 0};
      vt[6]  = '{1, 7, 32'hBEEF, 0, 0,  1, 7,  32'hCAFE,  0, 7, 0,             0,  0,  0, 0,        0,        1, 1, 0};
      vt[7]  = '{1, 7, 32'hBEEF, 0, 0,  0, 0,  0,         7, 7, 0,             1,  1,  7, 32'hCAFE, 32'hCAFE, 0, 0, 0};
      vt[8]  = '{0, 0, 0,        0, 0,  0, 0,  0,         7, 0, 32'hCAFE,      1,  1,  7, 32'hBEEF, 32'hBEEF, 0, 0, 0};
      vt[9]  = '{0, 0, 0,        1, 9,  0, 0,  0,         0, 0, 0,             1,  0,  0, 0,        0,        0, 0, 0};
      vt[10] = '{1, 4, 32'h44,   0, 0,  1, 9,  32'h99,    0, 9, 0,             0,  0,  0, 0,        0,        1, 1, 0};
      vt[11] = '{1, 4, 32'h44,   0, 0,  0, 0,  0,         0, 9, 0,             1,  1,  9, 32'h99,   0,        0, 0, 0};
      vt[12] = '{0, 0, 0,        0, 0,  0, 0,  0,         4, 0, 0,             1,  1,  4, 32'h44,   32'h44,   0, 0, 0};
      vt[13] = '{0, 0, 0,        0, 0,  1, 12, 32'h12,    0, 0, 0,             0,  0,  0, 0,        0,        0, 0, 0};
      vt[14] = '{0, 0, 0,        0, 0,  0, 0,  0,         0, 0, 0,             1,  0,  0, 0,        0,        0, 0, 1};
      vt[15] = '{0, 0, 0,        0, 0,  1, 0,  32'h77,    0, 0, 0,             0,  0,  0, 0,        0,        0, 0, 0};
      vt[16] = '{0, 0, 0,        0, 0,  0, 0,  0,         0, 0, 0,             1,  0,  0, 0,        0,        0, 0, 0};
      vt[17] = '{0, 0, 0,        1, 3,  0, 0,  0,         0, 3, 0,             1,  0,  0, 0,        0,        0, 0, 0};
      vt[18] = '{0, 0, 0,        1, 3,  1, 3,  32'h333,   0, 3, 0,             0,  0,  0, 0,        0,        1, 1, 0};
      vt[19] = '{0, 0, 0,        0, 0,  0, 0,  0,         3, 3, 0,             1,  1,  3, 32'h333,  32'h333,  1, 1, 0};

      idle();
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      #1;
      check("reset_w_ena", bus.o_w_ena, 0);
      check("reset_w_addr", bus.o_w_addr, 0);
      check("reset_w_data", bus.o_w_data, 0);
      check("reset_cnt", bus.o_pending_cnt, 0);
      check("reset_err", bus.o_ld_err, 0);

      for (int i = 0; i < 20; i++) begin
         drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].iss, vt[i].ird,
               vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].aa, vt[i].ba, vt[i].rfa, 0);
         #1;
         check($sformatf("vec%0d_alu_ready", i), bus.o_alu_ready, vt[i].e_rdy);
         check($sformatf("vec%0d_w_ena", i), bus.o_w_ena, vt[i].e_wen);
         if (vt[i].e_wen) begin
            check($sformatf("vec%0d_w_addr", i), bus.o_w_addr, vt[i].e_wa);
            check($sformatf("vec%0d_w_data", i), bus.o_w_data, vt[i].e_wd);
         end
         check($sformatf("vec%0d_a_data", i), bus.o_a_data, vt[i].e_ad);
         check($sformatf("vec%0d_b_hazard", i), bus.o_b_hazard, vt[i].e_bh);
         check($sformatf("vec%0d_cnt", i), bus.o_pending_cnt, vt[i].e_cnt);
         check($sformatf("vec%0d_ld_err", i), bus.o_ld_err, vt[i].e_err);
         tick();
      end

      // rd3 still pending: a second issue to it must be refused and ignored.
      drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("reissue_ready", bus.o_ld_issue_ready, 0);
      tick();
      idle();
      #1;
      check("reissue_cnt", bus.o_pending_cnt, 1);

      // Reset with a write in flight and loads outstanding.
      drive(1, 6, 32'h66, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      #1;
      check("midflight_cnt", bus.o_pending_cnt, 2);
      check("midflight_w_ena", bus.o_w_ena, 1);
      drive(1, 8, 32'h88, 1, 11, 1, 3, 32'h3, 3, 10, 0, 0);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      idle();
      bus.i_a_addr = 3;
      bus.i_b_addr = 10;
      #1;
      check("rst_w_ena", bus.o_w_ena, 0);
      check("rst_w_addr", bus.o_w_addr, 0);
      check("rst_w_data", bus.o_w_data, 0);
      check("rst_cnt", bus.o_pending_cnt, 0);
      check("rst_err", bus.o_ld_err, 0);
      check("rst_a_hazard", bus.o_a_hazard, 0);
      check("rst_b_hazard", bus.o_b_hazard, 0);

      // A load forgotten by reset returns: dropped, one-cycle error.
      drive(0, 0, 0, 0, 0, 1, 10, 32'hA, 0, 0, 0, 0);
      tick();
      idle();
      #1;
      check("stale_err", bus.o_ld_err, 1);
      check("stale_w_ena", bus.o_w_ena, 0);
      tick();
      check("stale_err_drop", bus.o_ld_err, 0);

      // Randomized traffic against the model, starting from a reset.
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_wv = 0; m_wa = 0; m_wd = 0; m_err = 0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         logic av, iss, lv, rst;
         logic [4:0] ard, ird, lrd, aa, ba;
         logic [31:0] ad, ld, rfa, rfb;
         logic e_rdy, e_irdy, acc, bad;
         int npend;
         logic [4:0] plist[$];

         plist = {};
         for (int r = 1; r < NREGS; r++) if (m_pend[r]) plist.push_back(5'(r));
         npend = plist.size();

         av  = 1'($urandom_range(0, 1));
         ard = 5'($urandom_range(0, 15));
         ad  = $urandom;
         iss = ($urandom_range(0, 2) == 0);
         ird = 5'($urandom_range(0, 15));
         lv  = ($urandom_range(0, 2) == 0);
         if (npend > 0 && $urandom_range(0, 3) != 0)
            lrd = plist[$urandom_range(0, npend - 1)];
         else
            lrd = 5'($urandom_range(0, 15));
         ld  = $urandom;
         aa  = 5'($urandom_range(0, 15));
         ba  = 5'($urandom_range(0, 15));
         rfa = $urandom;
         rfb = $urandom;
         rst = ($urandom_range(0, 79) == 0);

         drive(av, ard, ad, iss, ird, lv, lrd, ld, aa, ba, rfa, rfb);
         i_reset = rst;
         #1;

         acc    = lv && lrd != 0 && m_pend[lrd];
         bad    = lv && lrd != 0 && !m_pend[lrd];
         e_rdy  = !lv && !(ard != 0 && m_pend[ard]);
         e_irdy = ird == 0 || !m_pend[ird] || (acc && lrd == ird);

         check("rnd_alu_ready", bus.o_alu_ready, e_rdy);
         check("rnd_issue_ready", bus.o_ld_issue_ready, e_irdy);
         check("rnd_w_ena", bus.o_w_ena, m_wv && m_wa != 0);
         if (m_wv && m_wa != 0) begin
            check("rnd_w_addr", bus.o_w_addr, m_wa);
            check("rnd_w_data", bus.o_w_data, m_wd);
         end
         check("rnd_a_data", bus.o_a_data, m_fwd(aa, rfa));
         check("rnd_b_data", bus.o_b_data, m_fwd(ba, rfb));
         check("rnd_a_hazard", bus.o_a_hazard, aa != 0 && m_pend[aa]);
         check("rnd_b_hazard", bus.o_b_hazard, ba != 0 && m_pend[ba]);
         check("rnd_cnt", bus.o_pending_cnt, m_count());
         check("rnd_ld_err", bus.o_ld_err, m_err);

         tick();

         if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_wv = 0; m_wa = 0; m_wd = 0; m_err = 0;
         end else begin
            m_err = bad;
            if (acc) begin
               m_wv = 1; m_wa = lrd; m_wd = ld;
            end else if (av && e_rdy) begin
               m_wv = 1; m_wa = ard; m_wd = ad;
            end else begin
               m_wv = 0;
            end
            if (acc) m_pend[lrd] = 0;
            if (iss && ird != 0 && e_irdy) m_pend[ird] = 1;
         end
      end
      i_reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
